// File: rtl/spirose_pkg.sv
// Shared definitions for the ping-pong line buffer: bank state encoding and sizes.
package spirose_pkg;

   typedef enum logic [1:0] {
      BANK_FREE     = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_state_t;

   localparam int BANK_WORDS = 64;
   localparam int PIX_W      = 24;

endpackage

// File: rtl/ram_bank_fsm.sv
// Ownership state of one 64-word RAM bank: FREE -> FILLING -> FULL -> DRAINING -> FREE.
module ram_bank_fsm
   import spirose_pkg::*;
(
   input  logic        clk,
   input  logic        nrst,
   input  logic        i_fill_start,
   input  logic        i_fill_done,
   input  logic        i_sof_abort,
   input  logic        i_drain_start,
   input  logic        i_drain_done,
   output bank_state_t o_state
);

   bank_state_t r_state;

   // A start-of-line with a pixel in the same cycle restarts the fill rather than freeing the bank.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= BANK_FREE;
      end else begin
         case (r_state)
            BANK_FREE: begin
               if (i_fill_start) r_state <= BANK_FILLING;
            end
            BANK_FILLING: begin
               if (i_sof_abort)      r_state <= i_fill_start ? BANK_FILLING : BANK_FREE;
               else if (i_fill_done) r_state <= BANK_FULL;
            end
            BANK_FULL: begin
               if (i_drain_start) r_state <= BANK_DRAINING;
            end
            BANK_DRAINING: begin
               if (i_drain_done) r_state <= BANK_FREE;
            end
            default: r_state <= BANK_FREE;
         endcase
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/ram_pingpong_ctrl.sv
// Two-bank ping-pong sequencer for the 128x24 line RAM: pixel writer fills one bank
// while the serialiser drains the other as a 64-word burst.
module ram_pingpong_ctrl
   import spirose_pkg::*;
#(
   parameter int DATA_W = PIX_W,
   parameter int ADDR_W = 7
)(
   input  logic              clk,
   input  logic              nrst,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_sof,
   output logic              wr_ready,
   input  logic              rd_start,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              rd_busy,
   output logic              overflow,
   output logic              underrun,
   input  logic              clr_flags,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_wraddress,
   output logic              ram_wren,
   output logic [ADDR_W-1:0] ram_rdaddress,
   input  logic [DATA_W-1:0] ram_q
);

   localparam int              PTR_W     = ADDR_W - 1;
   localparam logic [PTR_W-1:0] LAST_WORD = PTR_W'(BANK_WORDS - 1);

   bank_state_t       w_state [2];
   logic              r_wrBank;
   logic              r_rdBank;
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [ADDR_W-1:0] r_rdAddr;
   logic              r_rdActive;
   logic              r_rdValid;
   logic              r_rdLast;
   logic              r_overflow;
   logic              r_underrun;

   logic              w_wrReady;
   logic              w_wrAccept;
   logic              w_sofAct;
   logic [PTR_W-1:0]  w_wrPtr;
   logic              w_fillDone;
   logic              w_rdBusy;
   logic              w_rdAccept;

   assign w_wrReady  = (w_state[r_wrBank] == BANK_FREE) || (w_state[r_wrBank] == BANK_FILLING);
   assign w_wrAccept = wr_valid & w_wrReady;
   assign w_sofAct   = wr_sof & w_wrReady;
   assign w_wrPtr    = w_sofAct ? '0 : r_wrPtr;
   assign w_fillDone = w_wrAccept & (w_wrPtr == LAST_WORD);
   assign w_rdBusy   = r_rdActive | r_rdValid;
   assign w_rdAccept = rd_start & ~w_rdBusy & (w_state[r_rdBank] == BANK_FULL);

   for (genvar gb = 0; gb < 2; gb++) begin : g_bank
      ram_bank_fsm u_bankFsm (
         .clk           (clk),
         .nrst          (nrst),
         .i_fill_start  (w_wrAccept & (r_wrBank == 1'(gb))),
         .i_fill_done   (w_fillDone & (r_wrBank == 1'(gb))),
         .i_sof_abort   (w_sofAct   & (r_wrBank == 1'(gb))),
         .i_drain_start (w_rdAccept & (r_rdBank == 1'(gb))),
         .i_drain_done  (r_rdLast   & (r_rdBank == 1'(gb))),
         .o_state       (w_state[gb])
      );
   end

   // The 6-bit pointer wraps to 0 by itself on the 64th write, as the bank flips to FULL.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wrPtr  <= '0;
         r_wrBank <= 1'b0;
      end else begin
         if (w_wrAccept)    r_wrPtr <= w_wrPtr + 1'b1;
         else if (w_sofAct) r_wrPtr <= '0;
         if (w_fillDone)    r_wrBank <= ~r_wrBank;
      end
   end

   // Address phase runs one cycle ahead of rd_valid to cover the RAM's registered read.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_rdActive <= 1'b0;
         r_rdPtr    <= '0;
         r_rdAddr   <= '0;
         r_rdValid  <= 1'b0;
         r_rdLast   <= 1'b0;
         r_rdBank   <= 1'b0;
      end else begin
         r_rdValid <= r_rdActive;
         r_rdLast  <= r_rdActive & (r_rdPtr == LAST_WORD);
         if (w_rdAccept) begin
            r_rdActive <= 1'b1;
            r_rdPtr    <= '0;
            r_rdAddr   <= {r_rdBank, {PTR_W{1'b0}}};
         end else if (r_rdActive) begin
            if (r_rdPtr == LAST_WORD) begin
               r_rdActive <= 1'b0;
            end else begin
               r_rdPtr  <= r_rdPtr + 1'b1;
               r_rdAddr <= {r_rdBank, r_rdPtr + 1'b1};
            end
         end
         if (r_rdLast) r_rdBank <= ~r_rdBank;
      end
   end

   // A fresh error outranks a simultaneous clear.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_overflow <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (wr_valid & ~w_wrReady) r_overflow <= 1'b1;
         else if (clr_flags)        r_overflow <= 1'b0;
         if (rd_start & ~w_rdAccept) r_underrun <= 1'b1;
         else if (clr_flags)         r_underrun <= 1'b0;
      end
   end

   assign wr_ready      = w_wrReady;
   assign ram_wren      = w_wrAccept;
   assign ram_wraddress = {r_wrBank, w_wrPtr};
   assign ram_data      = w_wrAccept ? wr_data : '0;
   assign ram_rdaddress = r_rdAddr;
   assign rd_valid      = r_rdValid;
   assign rd_last       = r_rdLast;
   assign rd_data       = r_rdValid ? ram_q : '0;
   assign rd_busy       = w_rdBusy;
   assign overflow      = r_overflow;
   assign underrun      = r_underrun;

endmodule

// File: tb/tb_ram_pingpong_ctrl.sv
// Bench for ram_pingpong_ctrl: directed and random traffic against a line-queue model,
// with a scoreboard monitor checking every read word, its timing and rd_last.
module tb_ram_pingpong_ctrl;

   localparam int DATA_W = 24;
   localparam int ADDR_W = 7;

   logic              clk = 1'b0;
   logic              nrst;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_sof;
   logic              wr_ready;
   logic              rd_start;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic              rd_busy;
   logic              overflow;
   logic              underrun;
   logic              clr_flags;
   logic [DATA_W-1:0] ram_data;
   logic [ADDR_W-1:0] ram_wraddress;
   logic              ram_wren;
   logic [ADDR_W-1:0] ram_rdaddress;
   logic [DATA_W-1:0] ram_q;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
      int                edgeNum;
   } exp_t;

   logic [DATA_W-1:0] ramMem [128];
   int                edgeCount = 0;
   int                checks    = 0;
   int                failures  = 0;

   // Reference model: words of the line being filled, complete lines awaiting a read,
   // and how many more edges the bank under burst stays occupied.
   exp_t              sbQueue [$];
   exp_t              monExp;
   logic [DATA_W-1:0] partialLine [$];
   logic [DATA_W-1:0] readyWords [$];
   int                drainLeft;
   bit                modelOvf;
   bit                modelUdr;
   bit                nextRdBank;
   bit                curBurstBank;
   int                streamVal;
   int                bursts;

   ram_pingpong_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .nrst          (nrst),
      .wr_valid      (wr_valid),
      .wr_data       (wr_data),
      .wr_sof        (wr_sof),
      .wr_ready      (wr_ready),
      .rd_start      (rd_start),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .rd_last       (rd_last),
      .rd_busy       (rd_busy),
      .overflow      (overflow),
      .underrun      (underrun),
      .clr_flags     (clr_flags),
      .ram_data      (ram_data),
      .ram_wraddress (ram_wraddress),
      .ram_wren      (ram_wren),
      .ram_rdaddress (ram_rdaddress),
      .ram_q         (ram_q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edgeCount <= edgeCount + 1;

   // External dual-port RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (ram_wren) ramMem[ram_wraddress] <= ram_data;
      ram_q <= ramMem[ram_rdaddress];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at edge %0d", name, actual, expected, edgeCount);
      end
   endtask

   function automatic bit modelWrReady();
      int occupied;
      occupied = readyWords.size() / 64 + ((drainLeft > 0) ? 1 : 0);
      return occupied < 2;
   endfunction

   // Pops one expected word whenever the DUT presents one, or flags a word that never came.
   always @(negedge clk) begin
      if (nrst) begin
         if (rd_valid) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpected rd_valid", 32'(1), 32'(0));
            end else begin
               monExp = sbQueue.pop_front();
               checkOutput("rd_data", 32'(rd_data), 32'(monExp.data));
               checkOutput("rd_last", 32'(rd_last), 32'(monExp.last));
               checkOutput("rd_valid edge", 32'(edgeCount), 32'(monExp.edgeNum));
            end
         end else if (sbQueue.size() > 0 && sbQueue[0].edgeNum <= edgeCount) begin
            monExp = sbQueue.pop_front();
            checkOutput("rd_valid missing", 32'(0), 32'(1));
         end
         if (rd_last && !rd_valid) checkOutput("rd_last without rd_valid", 32'(1), 32'(0));
      end
   end

   task automatic modelStep(input bit wv, input logic [DATA_W-1:0] wd, input bit sof,
                            input bit rs, input bit clr);
      bit wrRdy;
      bit rdOk;
      bit ovfEv;
      bit udrEv;
      wrRdy = modelWrReady();
      rdOk  = rs && (drainLeft == 0) && (readyWords.size() >= 64);
      if (drainLeft > 0) drainLeft--;
      if (rdOk) begin
         drainLeft    = 65;
         curBurstBank = nextRdBank;
         nextRdBank   = ~nextRdBank;
         for (int i = 0; i < 64; i++) begin
            exp_t e;
            e.data    = readyWords.pop_front();
            e.last    = (i == 63);
            e.edgeNum = edgeCount + 2 + i;
            sbQueue.push_back(e);
         end
      end
      if (sof && wrRdy) partialLine.delete();
      ovfEv = wv && !wrRdy;
      if (wv && wrRdy) begin
         partialLine.push_back(wd);
         if (partialLine.size() == 64) begin
            for (int i = 0; i < 64; i++) readyWords.push_back(partialLine[i]);
            partialLine.delete();
         end
      end
      udrEv = rs && !rdOk;
      if (ovfEv)    modelOvf = 1'b1;
      else if (clr) modelOvf = 1'b0;
      if (udrEv)    modelUdr = 1'b1;
      else if (clr) modelUdr = 1'b0;
   endtask

   task automatic applyStimulus(input bit wv, input logic [DATA_W-1:0] wd, input bit sof,
                                input bit rs, input bit clr);
      @(negedge clk);
      checkOutput("wr_ready", 32'(wr_ready), 32'(modelWrReady()));
      checkOutput("rd_busy", 32'(rd_busy), 32'(drainLeft > 0));
      checkOutput("overflow", 32'(overflow), 32'(modelOvf));
      checkOutput("underrun", 32'(underrun), 32'(modelUdr));
      if (drainLeft > 0)
         checkOutput("burst bank", 32'(ram_rdaddress[ADDR_W-1]), 32'(curBurstBank));
      wr_valid  = wv;
      wr_data   = wd;
      wr_sof    = sof;
      rd_start  = rs;
      clr_flags = clr;
      #1;
      checkOutput("ram_wren", 32'(ram_wren), 32'(wv && modelWrReady()));
      modelStep(wv, wd, sof, rs, clr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic waitDrain();
      int budget;
      budget = 0;
      while ((sbQueue.size() > 0 || drainLeft > 0) && budget < 300) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
         budget++;
      end
      if (sbQueue.size() > 0 || drainLeft > 0) checkOutput("drain timeout", 32'(0), 32'(1));
   endtask

   task automatic readBurst();
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      waitDrain();
   endtask

   task automatic doReset(input int holdCycles);
      nrst      = 1'b0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      wr_sof    = 1'b0;
      rd_start  = 1'b0;
      clr_flags = 1'b0;
      #1;
      checkOutput("reset wr_ready", 32'(wr_ready), 32'(1));
      checkOutput("reset rd_valid", 32'(rd_valid), 32'(0));
      checkOutput("reset rd_last", 32'(rd_last), 32'(0));
      checkOutput("reset rd_busy", 32'(rd_busy), 32'(0));
      checkOutput("reset overflow", 32'(overflow), 32'(0));
      checkOutput("reset underrun", 32'(underrun), 32'(0));
      checkOutput("reset ram_wren", 32'(ram_wren), 32'(0));
      checkOutput("reset ram_wraddress", 32'(ram_wraddress), 32'(0));
      checkOutput("reset ram_rdaddress", 32'(ram_rdaddress), 32'(0));
      checkOutput("reset ram_data", 32'(ram_data), 32'(0));
      checkOutput("reset rd_data", 32'(rd_data), 32'(0));
      partialLine.delete();
      readyWords.delete();
      sbQueue.delete();
      drainLeft  = 0;
      modelOvf   = 1'b0;
      modelUdr   = 1'b0;
      nextRdBank = 1'b0;
      repeat (holdCycles) @(negedge clk);
      nrst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 128; i++) ramMem[i] = '0;
      nrst       = 1'b1;
      wr_valid   = 1'b0;
      wr_data    = '0;
      wr_sof     = 1'b0;
      rd_start   = 1'b0;
      clr_flags  = 1'b0;
      drainLeft  = 0;
      modelOvf   = 1'b0;
      modelUdr   = 1'b0;
      nextRdBank = 1'b0;
      curBurstBank = 1'b0;
      #2;
      doReset(3);

      $display("[TB] rd_start with no data, then clear flags");
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      idle(3);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      idle(2);

      $display("[TB] single line 0x00..0x3F and one burst");
      for (int i = 0; i < 64; i++) applyStimulus(1'b1, 24'(i), 1'b0, 1'b0, 1'b0);
      readBurst();

      $display("[TB] 129 writes with no reads");
      for (int i = 0; i < 129; i++) applyStimulus(1'b1, 24'h100000 + 24'(i), 1'b0, 1'b0, 1'b0);
      idle(2);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      readBurst();
      readBurst();

      $display("[TB] partial line discarded by wr_sof");
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 24'h0BAD00 + 24'(i), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 64; i++) applyStimulus(1'b1, 24'hA00000 + 24'(i), 1'b0, 1'b0, 1'b0);
      readBurst();

      $display("[TB] streaming 8 bursts");
      streamVal = 24'h200000;
      bursts    = 0;
      for (int cyc = 0; cyc < 3000 && (bursts < 8 || drainLeft > 0 || sbQueue.size() > 0); cyc++) begin
         bit wv;
         bit rs;
         wv = modelWrReady() && ($urandom_range(0, 9) != 0) && (bursts < 8);
         rs = (drainLeft == 0) && (readyWords.size() >= 64) && (bursts < 8);
         if (rs) bursts++;
         applyStimulus(wv, 24'(streamVal), 1'b0, rs, 1'b0);
         if (wv) streamVal++;
      end
      checkOutput("stream bursts", 32'(bursts), 32'(8));
      waitDrain();

      $display("[TB] random traffic");
      for (int cyc = 0; cyc < 1500; cyc++) begin
         applyStimulus($urandom_range(0, 3) != 0, 24'($urandom),
                       $urandom_range(0, 47) == 0, $urandom_range(0, 23) == 0,
                       $urandom_range(0, 39) == 0);
      end
      waitDrain();

      $display("[TB] reset during burst word 20");
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      doReset(2);
      for (int i = 0; i < 64; i++) applyStimulus(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      idle(21);
      doReset(2);
      for (int i = 0; i < 64; i++) applyStimulus(1'b1, 24'h300000 + 24'(i), 1'b0, 1'b0, 1'b0);
      readBurst();
      idle(3);
      checkOutput("scoreboard empty", 32'(sbQueue.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
